// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: opcodes, instruction field
// positions and the writeback sequencer state encoding.
package wb_stage_pkg;

  // Opcodes that commit a register write
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;

  // Writeback sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_decode.sv
// Writeback destination decode: which instructions write the register file,
// to which register, and whether the data comes from memory. Purely
// combinational so hazard logic can share it.
module wb_decode
  import wb_stage_pkg::*;
#(
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  logic [31:0] ir_in,
  output logic        writes,
  output logic [4:0]  dest,
  output logic        sel_mem
);

  localparam logic [4:0] STATUS_IDX = 5'(STATUS_REG);
  localparam logic [4:0] LINK_IDX   = 5'(LINK_REG);

  logic [4:0] opcode;
  logic [4:0] rd;
  logic       unused_ir_bits;

  assign opcode         = ir_in[OPC_HI:OPC_LO];
  assign rd             = ir_in[RD_HI:RD_LO];
  assign unused_ir_bits = ^ir_in[RD_LO-1:0];

  // Map opcode to write enable, destination and data source
  always_comb begin
    writes  = 1'b0;
    dest    = 5'd0;
    sel_mem = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI: begin
        writes = 1'b1;
        dest   = rd;
      end
      OP_LW: begin
        writes  = 1'b1;
        dest    = rd;
        sel_mem = 1'b1;
      end
      OP_JAL: begin
        writes = 1'b1;
        dest   = LINK_IDX;
      end
      OP_SETX: begin
        writes = 1'b1;
        dest   = STATUS_IDX;
      end
      default: begin
        writes  = 1'b0;
        dest    = 5'd0;
        sel_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: drives the single register-file write port from the
// MEM/WB latch. An overflowing instruction needs two writes (result to rd,
// status to the status register), so it takes an extra PEND cycle during
// which the front of the pipeline is stalled. Also provides a one-cycle
// delayed bypass copy of the committed write and a retired-instruction count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int STATUS_REG = 30,
  parameter int LINK_REG   = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_in,
  input  logic [31:0] o_in,
  input  logic [31:0] d_in,
  input  logic        isRStatus_in,
  input  logic [31:0] rStatus_in,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        wb_stall,
  output logic        byp_valid,
  output logic [4:0]  byp_reg,
  output logic [31:0] byp_data,
  output logic [31:0] retired
);

  localparam logic [4:0] STATUS_IDX = 5'(STATUS_REG);

  wb_state_e   state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [31:0] retired_q, retired_d;
  logic        byp_valid_q, byp_valid_d;
  logic [4:0]  byp_reg_q, byp_reg_d;
  logic [31:0] byp_data_q, byp_data_d;

  logic        dec_writes;
  logic [4:0]  dec_dest;
  logic        dec_sel_mem;

  logic        we_c;
  logic [4:0]  reg_c;
  logic [31:0] data_c;
  logic        stall_c;

  wb_decode #(
    .STATUS_REG (STATUS_REG),
    .LINK_REG   (LINK_REG)
  ) u_decode (
    .ir_in   (ir_in),
    .writes  (dec_writes),
    .dest    (dec_dest),
    .sel_mem (dec_sel_mem)
  );

  // Write-port sequencing: decoded write in IDLE, deferred status write in PEND
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    we_c     = 1'b0;
    reg_c    = 5'd0;
    data_c   = 32'd0;
    stall_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (isRStatus_in) begin
          if (!dec_writes || dec_dest == 5'd0 || dec_dest == STATUS_IDX) begin
            // Only the status has somewhere to go: one write, no stall
            we_c   = 1'b1;
            reg_c  = STATUS_IDX;
            data_c = rStatus_in;
          end else begin
            // Result now, status next cycle
            we_c     = 1'b1;
            reg_c    = dec_dest;
            data_c   = o_in;
            stall_c  = 1'b1;
            status_d = rStatus_in;
            state_d  = ST_PEND;
          end
        end else if (dec_writes && dec_dest != 5'd0) begin
          we_c   = 1'b1;
          reg_c  = dec_dest;
          data_c = dec_sel_mem ? d_in : o_in;
        end
      end
      ST_PEND: begin
        // Latch still holds the overflowing instruction; ignore it
        we_c    = 1'b1;
        reg_c   = STATUS_IDX;
        data_c  = status_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bypass copy and retired count follow the committed write
  always_comb begin
    byp_valid_d = ctrl_writeEnable;
    byp_reg_d   = ctrl_writeReg;
    byp_data_d  = data_writeReg;
    retired_d   = retired_q;
    if (state_q == ST_IDLE && ir_in != 32'd0) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // Control, bypass and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      retired_q   <= 32'd0;
      byp_valid_q <= 1'b0;
      byp_reg_q   <= 5'd0;
      byp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      byp_valid_q <= byp_valid_d;
      byp_reg_q   <= byp_reg_d;
      byp_data_q  <= byp_data_d;
    end
  end

  // Pending status capture; only meaningful while in PEND
  always_ff @(posedge clock) begin
    status_q <= status_d;
  end

  // Write port is held quiet while reset is asserted
  assign ctrl_writeEnable = reset & we_c;
  assign ctrl_writeReg    = reset ? reg_c : 5'd0;
  assign data_writeReg    = reset ? data_c : 32'd0;
  assign wb_stall         = reset & stall_c;

  assign byp_valid = byp_valid_q;
  assign byp_reg   = byp_reg_q;
  assign byp_data  = byp_data_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: single writes, load data select, overflow
// sequencing, r0/no-write cases, bypass lag, retire count and reset in PEND.
module tb_wb_stage;

  logic        clock;
  logic        reset;
  logic [31:0] ir_in;
  logic [31:0] o_in;
  logic [31:0] d_in;
  logic        isRStatus_in;
  logic [31:0] rStatus_in;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_stall;
  logic        byp_valid;
  logic [4:0]  byp_reg;
  logic [31:0] byp_data;
  logic [31:0] retired;

  int n_vec;
  int n_miss;

  wb_stage #(
    .STATUS_REG (30),
    .LINK_REG   (31)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ir_in            (ir_in),
    .o_in             (o_in),
    .d_in             (d_in),
    .isRStatus_in     (isRStatus_in),
    .rStatus_in       (rStatus_in),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_stall         (wb_stall),
    .byp_valid        (byp_valid),
    .byp_reg          (byp_reg),
    .byp_data         (byp_data),
    .retired          (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
    mk = {op, rd, 22'h0};
  endfunction

  // Advance to the next edge, then present a new latch word 1ns later
  task automatic step(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                      input logic isr, input logic [31:0] rs);
    @(posedge clock);
    #1;
    ir_in        = ir;
    o_in         = o;
    d_in         = d;
    isRStatus_in = isr;
    rStatus_in   = rs;
    #3;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rg,
                        input logic [31:0] dat, input logic st);
    chk({tag, ".we"}, {31'd0, ctrl_writeEnable}, {31'd0, we});
    if (we) begin
      chk({tag, ".reg"}, {27'd0, ctrl_writeReg}, {27'd0, rg});
      chk({tag, ".data"}, data_writeReg, dat);
    end
    chk({tag, ".stall"}, {31'd0, wb_stall}, {31'd0, st});
  endtask

  task automatic chk_byp(input string tag, input logic v, input logic [4:0] rg,
                         input logic [31:0] dat);
    chk({tag, ".bv"}, {31'd0, byp_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".breg"}, {27'd0, byp_reg}, {27'd0, rg});
      chk({tag, ".bdata"}, byp_data, dat);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b0;
    ir_in        = 32'd0;
    o_in         = 32'd0;
    d_in         = 32'd0;
    isRStatus_in = 1'b0;
    rStatus_in   = 32'd0;

    // Reset state, with a writing instruction on the latch
    #12;
    ir_in = mk(5'b00101, 5'd9);
    o_in  = 32'h55;
    #1;
    chk("rst.we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst.reg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst.data", data_writeReg, 32'd0);
    chk("rst.ret", retired, 32'd0);
    chk_byp("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.breg0", {27'd0, byp_reg}, 32'd0);
    chk("rst.bdata0", byp_data, 32'd0);
    ir_in = 32'd0;
    o_in  = 32'd0;
    #2;
    reset = 1'b1;

    // addi r5
    step(mk(5'b00101, 5'd5), 32'h1234, 32'd0, 1'b0, 32'd0);
    chk_wr("addi", 1'b1, 5'd5, 32'h1234, 1'b0);
    chk("addi.ret", retired, 32'd0);

    // lw r7 takes load data
    step(mk(5'b01000, 5'd7), 32'h40, 32'hDEADBEEF, 1'b0, 32'd0);
    chk_wr("lw", 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    chk_byp("lw", 1'b1, 5'd5, 32'h1234);
    chk("lw.ret", retired, 32'd1);

    // add r3 overflows: two cycles
    step(mk(5'b00000, 5'd3), 32'h80000000, 32'd0, 1'b1, 32'd1);
    chk_wr("ovf.n", 1'b1, 5'd3, 32'h80000000, 1'b1);
    chk_byp("ovf.n", 1'b1, 5'd7, 32'hDEADBEEF);
    chk("ovf.n.ret", retired, 32'd2);
    step(mk(5'b00000, 5'd3), 32'h80000000, 32'd0, 1'b1, 32'd1);
    chk_wr("ovf.n1", 1'b1, 5'd30, 32'd1, 1'b0);
    chk_byp("ovf.n1", 1'b1, 5'd3, 32'h80000000);
    chk("ovf.n1.ret", retired, 32'd3);

    // overflow into r0: single status write, no stall
    step(mk(5'b00101, 5'd0), 32'h7, 32'd0, 1'b1, 32'd5);
    chk_wr("ovf0", 1'b1, 5'd30, 32'd5, 1'b0);
    chk_byp("ovf0", 1'b1, 5'd30, 32'd1);
    chk("ovf0.ret", retired, 32'd3);

    // jal writes link register
    step(mk(5'b00011, 5'd0), 32'h15, 32'd0, 1'b0, 32'd0);
    chk_wr("jal", 1'b1, 5'd31, 32'h15, 1'b0);
    chk("jal.ret", retired, 32'd4);

    // bubbles: no writes, count frozen
    step(32'd0, 32'h99, 32'h99, 1'b0, 32'd0);
    chk_wr("nop0", 1'b0, 5'd0, 32'd0, 1'b0);
    chk_byp("nop0", 1'b1, 5'd31, 32'h15);
    chk("nop0.ret", retired, 32'd5);
    step(32'd0, 32'h99, 32'h99, 1'b0, 32'd0);
    chk_wr("nop1", 1'b0, 5'd0, 32'd0, 1'b0);
    chk_byp("nop1", 1'b0, 5'd0, 32'd0);
    step(32'd0, 32'h99, 32'h99, 1'b0, 32'd0);
    chk_wr("nop2", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("nop2.ret", retired, 32'd5);

    // back-to-back overflows
    step(mk(5'b00101, 5'd4), 32'h11, 32'd0, 1'b1, 32'd2);
    chk_wr("b2b.a", 1'b1, 5'd4, 32'h11, 1'b1);
    step(mk(5'b00101, 5'd4), 32'h11, 32'd0, 1'b1, 32'd2);
    chk_wr("b2b.ap", 1'b1, 5'd30, 32'd2, 1'b0);
    step(mk(5'b00000, 5'd6), 32'h22, 32'd0, 1'b1, 32'd3);
    chk_wr("b2b.b", 1'b1, 5'd6, 32'h22, 1'b1);
    chk("b2b.b.ret", retired, 32'd6);
    step(mk(5'b00000, 5'd6), 32'h22, 32'd0, 1'b1, 32'd3);
    chk_wr("b2b.bp", 1'b1, 5'd30, 32'd3, 1'b0);
    chk("b2b.bp.ret", retired, 32'd7);

    // addi to r0 without overflow and a non-writing opcode
    step(mk(5'b00101, 5'd0), 32'h33, 32'd0, 1'b0, 32'd0);
    chk_wr("r0", 1'b0, 5'd0, 32'd0, 1'b0);
    step(mk(5'b00111, 5'd8), 32'h44, 32'd0, 1'b0, 32'd0);
    chk_wr("sw", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("sw.ret", retired, 32'd8);

    // setx writes status register
    step(mk(5'b10101, 5'd0), 32'h77, 32'd0, 1'b0, 32'd0);
    chk_wr("setx", 1'b1, 5'd30, 32'h77, 1'b0);

    // reset asserted in the middle of PEND
    step(mk(5'b00101, 5'd9), 32'h66, 32'd0, 1'b1, 32'd9);
    chk_wr("rp.n", 1'b1, 5'd9, 32'h66, 1'b1);
    @(posedge clock);
    #1;
    chk_wr("rp.pend", 1'b1, 5'd30, 32'd9, 1'b0);
    reset        = 1'b0;
    ir_in        = 32'd0;
    isRStatus_in = 1'b0;
    #1;
    chk("rp.we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rp.ret", retired, 32'd0);
    chk("rp.bv", {31'd0, byp_valid}, 32'd0);
    #3;
    reset = 1'b1;
    step(32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk_wr("rp.after", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rp.after.ret", retired, 32'd0);
    chk("rp.after.bv", {31'd0, byp_valid}, 32'd0);
    step(mk(5'b00101, 5'd2), 32'hAB, 32'd0, 1'b0, 32'd0);
    chk_wr("rp.idle", 1'b1, 5'd2, 32'hAB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipeline: consumes the MEM/WB latch outputs (`ir`, `o`, `d`, `isRStatus`, `rStatus`) and drives the register file's single write port. An overflowing instruction commits both its wrapped result to `rd` and its status code to r30. That takes two writes through one port, so the block sequences them across two cycles and stalls the front of the pipeline for one cycle. It also registers the last committed write as a bypass source for decode and counts retired instructions.

## Interface
- `STATUS_REG`, default 30: register receiving status codes and `setx` values.
- `LINK_REG`, default 31: register receiving `jal` return address.
- `clock` input 1: pipeline clock.
- `reset` input 1: asynchronous, active-low.
- `ir_in` input 32: instruction from MEM/WB latch.
- `o_in` input 32: ALU result, PC+1 for `jal`, or T for `setx`.
- `d_in` input 32: load data.
- `isRStatus_in` input 1: instruction raised a status (overflow).
- `rStatus_in` input 32: status code.
- `ctrl_writeEnable` output 1: register file write enable.
- `ctrl_writeReg` output 5: destination register.
- `data_writeReg` output 32: write data.
- `wb_stall` output 1: hold MEM/WB latch and freeze upstream stages this cycle.
- `byp_valid` output 1, `byp_reg` output 5, `byp_data` output 32: last committed write, registered.
- `retired` output 32: retired-instruction count.

## Operation
- Decode, with opcode = `ir_in[31:27]`:
  - R-type 00000, `addi` 00101, `lw` 01000 write `rd` = `ir_in[26:22]`.
  - `jal` 00011 writes `LINK_REG`.
  - `setx` 10101 writes `STATUS_REG`.
  - All other opcodes write nothing.
- Data select: `d_in` for `lw`; `o_in` otherwise.
- Writes to r0 are suppressed (`ctrl_writeEnable`=0).
- FSM states:
  - IDLE: drive decoded write combinationally. If `isRStatus_in`=1:
    - Destination is r0 or `STATUS_REG`, or no write: single write of `rStatus_in` to `STATUS_REG`. No stall.
    - Otherwise: write `o_in` to `rd`, assert `wb_stall`, capture `rStatus_in`, go PEND.
  - PEND: write captured status to `STATUS_REG`. `wb_stall`=0 and latch inputs are ignored. Next state is IDLE.
- `retired` increments by 1 at the end of each IDLE cycle where `ir_in` ≠ 0. PEND cycles never count. Wraps 0xFFFFFFFF→0.
- Bypass: at every clock edge, `byp_*` load this cycle's `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg`.

## Timing
- Write-port outputs are combinational from the latch (IDLE) or the capture register (PEND). The register file commits them at the next edge.
- Overflow sequence:
  - Cycle N: IDLE, `rd` write, `wb_stall`=1.
  - Cycle N+1: PEND, r30 write; latch still holds the same instruction.
  - Cycle N+2: next instruction.
- Back-to-back overflows: each costs exactly one PEND cycle. No status is lost.
- `byp_*` lag the write by one cycle. This covers decode reading a register written in the same cycle.
- Reset asserted (low), including mid-PEND: state→IDLE, pending status dropped, `retired`=0, `byp_valid`=0, `byp_reg`=0, `byp_data`=0. Combinational write outputs are 0 while reset is low.
- First edge after reset release behaves as IDLE.

## Structure
- Shared package/include holds:
  - Opcode constants (R-type, `addi`, `lw`, `jal`, `setx`).
  - Field bit positions.
  - State encoding: IDLE=0, PEND=1.
- One combinational sub-module `wb_decode`: `ir_in` → `writes`, `dest[4:0]`, `sel_mem`. Reused by hazard logic.
- Top holds the FSM, status capture register, bypass registers and counter.

## Test plan
- `addi` r5 with `o_in`=0x1234, `isRStatus_in`=0:
  - Cycle 1: `ctrl_writeEnable`=1, reg 5, data 0x1234, `wb_stall`=0.
  - Next cycle: `byp_reg`=5, `byp_data`=0x1234; `retired`=1.
- `lw` r7, `d_in`=0xDEADBEEF, `o_in`=0x40 → writes 0xDEADBEEF to r7.
- R-type add r3, overflow, `o_in`=0x80000000, `rStatus_in`=1:
  - Cycle N: r3←0x80000000, `wb_stall`=1.
  - Cycle N+1: r30←1, `wb_stall`=0.
  - `retired` increments once.
- Overflow with `rd`=0 → single cycle, r30←`rStatus_in`, no stall. `jal` with `o_in`=0x15 → r31←0x15.
- Reset driven low during PEND → next cycle IDLE, no r30 write, `retired`=0, `byp_valid`=0.
- `ir_in`=0 for 3 cycles → no writes; `retired` unchanged.
